tx_output_ramp: RTL and testbench

TX_OUTPUT_RAMP -- requirements
Module: tx_output_ramp

---
 rtl/tx_output_ramp.sv | 93 +++++++++
 tb/tb_tx_output_ramp.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tx_output_ramp.sv
// tx_output_ramp: gain ramp FSM plus a 2-stage per-lane gain multiplier; the peak detector exists only with TX_OUTPUT_RAMP_PEAK_EN.
// Until a nonzero ramp_step has been seen after reset, a zero ramp_step acts as RAMP_RESET_STEP.
module tx_output_ramp #(
  parameter int NUMBER_OF_LINE = 8,
  parameter logic [7:0] RAMP_RESET_STEP = 8'd1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         tx_enable,
  input  logic [7:0]                   ramp_step,
  input  logic [16*NUMBER_OF_LINE-1:0] in_data,
  input  logic                         in_valid,
  output logic [16*NUMBER_OF_LINE-1:0] out_data,
  output logic                         out_valid,
  output logic [1:0]                   ramp_state,
  output logic [8:0]                   gain,
  input  logic                         peak_clear,
  output logic [15:0]                  peak_abs
);
  typedef enum logic [1:0] {MUTED = 2'd0, RAMP_UP = 2'd1, ACTIVE = 2'd2, RAMP_DOWN = 2'd3} state_t;
  state_t r_state;
  logic [8:0] r_gain;
  logic r_fresh;
  logic [7:0] w_step;
  logic [9:0] w_up;
  logic [8:0] w_next;
  always_comb begin
    w_step = (ramp_step == 8'd0 && r_fresh) ? RAMP_RESET_STEP : ramp_step;
    w_up = {1'b0, r_gain} + {2'b00, w_step};
    w_next = tx_enable ? (w_up > 10'd256 ? 9'd256 : w_up[8:0])
                       : (r_gain > {1'b0, w_step} ? r_gain - {1'b0, w_step} : 9'd0);
  end
  // Direction follows tx_enable in every state, so reversals continue from the current gain.
  always_ff @(posedge clock)
    if (reset) begin
      r_state <= MUTED;
      r_gain <= '0;
      r_fresh <= 1'b1;
    end else begin
      r_gain <= w_next;
      r_fresh <= r_fresh && ramp_step == 8'd0;
      r_state <= tx_enable ? (w_next == 9'd256 ? ACTIVE : RAMP_UP) : (w_next == 9'd0 ? MUTED : RAMP_DOWN);
    end
  logic signed [24:0] r_prod [NUMBER_OF_LINE];
  logic r_v1, r_ov;
  logic [16*NUMBER_OF_LINE-1:0] r_out;
  always_ff @(posedge clock)
    if (reset) begin
      r_v1 <= 1'b0;
      r_ov <= 1'b0;
      r_out <= '0;
      for (int k = 0; k < NUMBER_OF_LINE; k++) r_prod[k] <= '0;
    end else begin
      r_v1 <= in_valid;
      r_ov <= r_v1;
      for (int k = 0; k < NUMBER_OF_LINE; k++) begin
        if (in_valid) r_prod[k] <= $signed(in_data[16*k +: 16]) * $signed({1'b0, r_gain});
        if (r_v1) r_out[16*k +: 16] <= r_prod[k][23:8];
      end
    end
  // Product range is [-2^23, 2^23), so the sign bit duplicates bit 23 and the low byte is shifted out.
  logic w_unused_prod;
  always_comb begin
    w_unused_prod = 1'b0;
    for (int k = 0; k < NUMBER_OF_LINE; k++) w_unused_prod = w_unused_prod ^ (^{r_prod[k][24], r_prod[k][7:0]});
  end
  assign out_data = r_out;
  assign out_valid = r_ov;
  assign ramp_state = r_state;
  assign gain = r_gain;
`ifdef TX_OUTPUT_RAMP_PEAK_EN
  logic [15:0] r_peak, w_lmax, w_abs, w_lane;
  always_comb begin
    w_lmax = '0;
    w_abs = '0;
    w_lane = '0;
    for (int k = 0; k < NUMBER_OF_LINE; k++) begin
      w_lane = r_out[16*k +: 16];
      w_abs = w_lane == 16'h8000 ? 16'h7fff : (w_lane[15] ? ~w_lane + 16'd1 : w_lane);
      w_lmax = w_abs > w_lmax ? w_abs : w_lmax;
    end
  end
  always_ff @(posedge clock)
    if (reset) r_peak <= '0;
    else if (peak_clear) r_peak <= r_ov ? w_lmax : 16'd0;
    else if (r_ov && w_lmax > r_peak) r_peak <= w_lmax;
  assign peak_abs = r_peak;
`else
  logic w_unused_clr;
  assign w_unused_clr = peak_clear;
  assign peak_abs = 16'd0;
`endif
endmodule

// File: tb/tb_tx_output_ramp.sv
// tb_tx_output_ramp: table-driven ramp vectors, directed datapath/peak cases and a randomized run against a behavioural model.
module tb_tx_output_ramp;
  localparam int N = 8;
  localparam int W = 16 * N;
  localparam int RRS = 1;
  logic clock = 1'b0;
  logic reset, tx_enable, in_valid, out_valid, peak_clear;
  logic [7:0] ramp_step;
  logic [W-1:0] in_data, out_data;
  logic [1:0] ramp_state;
  logic [8:0] gain;
  logic [15:0] peak_abs;
  int checks = 0;
  int errors = 0;
  int m_gain, m_state;
  bit m_fresh, m_v1, m_ov;
  logic [W-1:0] m_s1, m_out;
  logic [15:0] m_peak;
  always #5 clock = ~clock;
  tx_output_ramp #(.NUMBER_OF_LINE(N), .RAMP_RESET_STEP(8'(RRS))) dut (
    .clock(clock), .reset(reset), .tx_enable(tx_enable), .ramp_step(ramp_step),
    .in_data(in_data), .in_valid(in_valid), .out_data(out_data), .out_valid(out_valid),
    .ramp_state(ramp_state), .gain(gain), .peak_clear(peak_clear), .peak_abs(peak_abs)
  );
  typedef struct {
    logic rst;
    logic en;
    logic [7:0] step;
    logic iv;
    logic [8:0] g;
    logic [1:0] st;
  } vec_t;
  vec_t tv [26];
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    int s;
    logic [15:0] a, lm;
    @(posedge clock);
    if (reset) begin
      m_gain = 0; m_state = 0; m_fresh = 1'b1; m_v1 = 1'b0; m_ov = 1'b0; m_out = '0; m_s1 = '0; m_peak = '0;
    end else begin
      lm = '0;
      for (int k = 0; k < N; k++) begin
        a = m_out[16*k +: 16];
        a = (a == 16'h8000) ? 16'h7fff : (a[15] ? -a : a);
        if (a > lm) lm = a;
      end
      if (peak_clear) m_peak = m_ov ? lm : 16'd0;
      else if (m_ov && lm > m_peak) m_peak = lm;
      if (m_v1) m_out = m_s1;
      m_ov = m_v1;
      if (in_valid)
        for (int k = 0; k < N; k++) m_s1[16*k +: 16] = 16'((int'($signed(in_data[16*k +: 16])) * m_gain) >>> 8);
      m_v1 = in_valid;
      s = (ramp_step == 8'd0 && m_fresh) ? RRS : int'(ramp_step);
      if (ramp_step != 8'd0) m_fresh = 1'b0;
      m_gain = tx_enable ? ((m_gain + s > 256) ? 256 : m_gain + s) : ((m_gain - s < 0) ? 0 : m_gain - s);
      m_state = tx_enable ? (m_gain == 256 ? 2 : 1) : (m_gain == 0 ? 0 : 3);
    end
    #1;
    chk("gain", W'(gain), W'(m_gain));
    chk("state", W'(ramp_state), W'(m_state));
    chk("out_valid", W'(out_valid), W'(m_ov));
    chk("out_data", out_data, m_out);
`ifdef TX_OUTPUT_RAMP_PEAK_EN
    chk("peak_abs", W'(peak_abs), W'(m_peak));
`else
    chk("peak_tied", W'(peak_abs), W'(0));
`endif
  endtask
  initial begin
    int r;
    reset = 1'b1; tx_enable = 1'b0; ramp_step = '0; in_valid = 1'b0; peak_clear = 1'b0;
    in_data = {N{16'h1234}};
    m_gain = 0; m_state = 0; m_fresh = 1'b1; m_v1 = 1'b0; m_ov = 1'b0; m_out = '0; m_s1 = '0; m_peak = '0;
    tv = '{
      '{1'b1, 1'b1, 8'd64,  1'b0, 9'd0,   2'd0},
      '{1'b0, 1'b1, 8'd64,  1'b0, 9'd64,  2'd1},
      '{1'b0, 1'b1, 8'd64,  1'b0, 9'd128, 2'd1},
      '{1'b0, 1'b1, 8'd64,  1'b0, 9'd192, 2'd1},
      '{1'b0, 1'b1, 8'd64,  1'b0, 9'd256, 2'd2},
      '{1'b0, 1'b1, 8'd5,   1'b0, 9'd256, 2'd2},
      '{1'b0, 1'b0, 8'd106, 1'b0, 9'd150, 2'd3},
      '{1'b0, 1'b0, 8'd100, 1'b0, 9'd50,  2'd3},
      '{1'b0, 1'b0, 8'd100, 1'b0, 9'd0,   2'd0},
      '{1'b0, 1'b0, 8'd10,  1'b0, 9'd0,   2'd0},
      '{1'b0, 1'b1, 8'd32,  1'b0, 9'd32,  2'd1},
      '{1'b0, 1'b1, 8'd32,  1'b0, 9'd64,  2'd1},
      '{1'b0, 1'b1, 8'd32,  1'b0, 9'd96,  2'd1},
      '{1'b0, 1'b0, 8'd32,  1'b0, 9'd64,  2'd3},
      '{1'b0, 1'b0, 8'd0,   1'b0, 9'd64,  2'd3},
      '{1'b0, 1'b0, 8'd0,   1'b0, 9'd64,  2'd3},
      '{1'b0, 1'b1, 8'd0,   1'b0, 9'd64,  2'd1},
      '{1'b0, 1'b1, 8'd100, 1'b1, 9'd164, 2'd1},
      '{1'b0, 1'b1, 8'd36,  1'b1, 9'd200, 2'd1},
      '{1'b1, 1'b1, 8'd36,  1'b0, 9'd0,   2'd0},
      '{1'b0, 1'b1, 8'd0,   1'b0, 9'd1,   2'd1},
      '{1'b0, 1'b1, 8'd0,   1'b0, 9'd2,   2'd1},
      '{1'b0, 1'b1, 8'd255, 1'b0, 9'd256, 2'd2},
      '{1'b0, 1'b0, 8'd0,   1'b0, 9'd256, 2'd3},
      '{1'b0, 1'b0, 8'd0,   1'b0, 9'd256, 2'd3},
      '{1'b0, 1'b1, 8'd0,   1'b0, 9'd256, 2'd2}
    };
    for (int i = 0; i < 26; i++) begin
      reset = tv[i].rst; tx_enable = tv[i].en; ramp_step = tv[i].step; in_valid = tv[i].iv;
      tick();
      chk($sformatf("tbl%0d_gain", i), W'(gain), W'(tv[i].g));
      chk($sformatf("tbl%0d_state", i), W'(ramp_state), W'(tv[i].st));
      if (i == 0) chk("rst_out_data", out_data, '0);
      if (i == 19) chk("rst_out_valid", W'(out_valid), W'(0));
    end
    in_data = {N{16'h4000}}; in_valid = 1'b1; tx_enable = 1'b1; ramp_step = 8'd1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("dp_full_data", out_data, {N{16'h4000}});
    chk("dp_full_valid", W'(out_valid), W'(1));
    in_data = '0;
    tick();
    chk("dp_hold_data", out_data, {N{16'h4000}});
    chk("dp_hold_valid", W'(out_valid), W'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0; ramp_step = 8'd128;
    tick();
    chk("half_gain", W'(gain), W'(128));
    ramp_step = 8'd0; in_data = {N{16'hfffd}}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("dp_floor", out_data, {N{16'hfffe}});
    ramp_step = 8'd200;
    tick();
    chk("reach_active", W'(ramp_state), W'(2));
    in_data = '0;
    in_data[15:0] = 16'h8000;
    in_data[31:16] = 16'd100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
`ifdef TX_OUTPUT_RAMP_PEAK_EN
    chk("peak_sat", W'(peak_abs), W'(16'h7fff));
`endif
    peak_clear = 1'b1;
    tick();
    peak_clear = 1'b0;
    chk("peak_clear", W'(peak_abs), W'(0));
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) tx_enable = ~tx_enable;
      r = $urandom_range(0, 7);
      ramp_step = (r == 0) ? 8'd0 : (r < 4) ? 8'($urandom_range(1, 16)) : 8'($urandom);
      in_valid = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < N; k++) begin
        r = $urandom_range(0, 7);
        in_data[16*k +: 16] = (r == 0) ? 16'h8000 : (r == 1) ? 16'h7fff : 16'($urandom);
      end
      peak_clear = ($urandom_range(0, 15) == 0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
